draw_scheduler: RTL
===================

// Module: draw_scheduler
// PURPOSE
//  Shares the single VGA frame-buffer write port among three requesters: screen clear, erase and draw.
//  The gameplay FSM issues erase requests for the old position of the moving block and draw requests for its new one.
//  The block grants one requester at a time and scans its rectangle pixel by pixel, one pixel per clock.
//  It pulses a per-requester done when the rectangle is finished. It sits between gameplay control/datapath and the VGA adapter.
// PARAMETERS
//  SCREEN_W  160     visible width in pixels
//  SCREEN_H  120     visible height in pixels
//  X_W       8       x coordinate / width bits
//  Y_W       7       y coordinate bits
//  BLOCK_H   4       rectangle height in pixels (one tower row)
//  COLOR_W   3       colour bits
//  BG_COLOR  3'b000  colour used by clear and erase
// PORTS
//  clk         in   1        clock
//  resetn      in   1        synchronous, active-low reset
//  clear_req   in   1        request full-screen clear; level, held until clear_done
//  erase_req   in   1        request erase of rectangle; level, held until erase_done
//  erase_x     in   X_W      erase rectangle left x
//  erase_y     in   Y_W      erase rectangle top y
//  erase_w     in   X_W      erase rectangle width
//  draw_req    in   1        request draw of rectangle; level, held until draw_done
//  draw_x      in   X_W      draw rectangle left x
//  draw_y      in   Y_W      draw rectangle top y
//  draw_w      in   X_W      draw rectangle width
//  draw_color  in   COLOR_W  draw colour
//  hold        in   1        VGA port stall; freezes the scan
//  plot        out  1        pixel write strobe
//  vga_x       out  X_W      pixel x
//  vga_y       out  Y_W      pixel y
//  vga_colour  out  COLOR_W  pixel colour
//  clear_done  out  1        1-cycle pulse: clear finished
//  erase_done  out  1        1-cycle pulse: erase finished
//  draw_done   out  1        1-cycle pulse: draw finished
//  busy        out  1        high in any state other than IDLE
// BEHAVIOUR
//  States: IDLE, CLEAR, ERASE, DRAW, DONE.
//  IDLE: fixed priority clear > erase > draw. On grant:
//   - latch base x/y, width and colour of the winner (clear: 0, 0, SCREEN_W, height SCREEN_H; erase uses BG_COLOR);
//   - zero px/py;
//   - go to the matching scan state.
//  Scan states: each non-held cycle emits the pixel (base_x+px, base_y+py), then advances row-major.
//   - px increments; at px==w-1, px wraps to 0 and py increments.
//   - Last pixel is px==w-1 and py==h-1 (h = BLOCK_H, or SCREEN_H for clear); the next state is DONE.
//  DONE: lasts 1 cycle and pulses the done of the granted requester only, then returns to IDLE.
//   - IDLE re-arbitrates on the following cycle, so a still-high req is treated as a new request.
//  Latency: req high at edge N (state IDLE) -> pixel 0 visible in cycle N+1.
//   - n-pixel rectangle -> done high in cycle N+n+1 (no hold) -> IDLE in cycle N+n+2.
//  Outputs are combinational from registered state/counters/latches only; there is no input-to-output path.
//  plot = scan state & ~hold & in-bounds. In IDLE and DONE, plot/vga_x/vga_y/vga_colour are 0.
//  hold=1: px/py/state frozen and plot=0; scanning resumes at the same pixel when hold drops.
//  Clipping: a pixel with x>=SCREEN_W or y>=SCREEN_H, or whose sum overflows, gets plot=0.
//   - The pixel still consumes its cycle.
//  Width 0: on grant go straight to DONE; no plots, done still pulses.
//  Req deasserted mid-scan: ignored; the scan completes and done still pulses.
//  Inputs changing mid-scan: ignored, because the values latched at grant are used.
//  Reset (any state, including mid-scan) -> IDLE on the next edge.
//   - All counters and latches are 0; no done pulse is issued.
//   - Reset values: plot=0, vga_x=0, vga_y=0, vga_colour=0, all dones=0, busy=0.
//  Counter widths: px X_W bits; py Y_W bits. Sums are computed at X_W+1 / Y_W+1 bits for the overflow check.
// STRUCTURE
//  Shared package: state encodings, SCREEN_W/H, BG_COLOR, colour code constants.
//  Sub-module: rect_scan_counter (px/py with wrap, hold freeze, last-pixel flag).
//  Arbiter, latches and output muxing live in this module.
// TESTING
//  1. draw_req x=10 y=20 w=3 colour=3'b100.
//     -> 12 plots (10..12, 20..23) in row-major order; draw_done in cycle 13 after grant; busy falls after that.
//  2. erase_req and draw_req raised on the same edge.
//     -> full erase in BG_COLOR, erase_done; IDLE for 1 cycle; then draw; draw_done. No interleaving.
//  3. draw x=158 w=4.
//     -> plots only at x=158 and x=159 per row (8 plots); done still after 16 scan cycles.
//  4. clear_req.
//     -> 19200 plots of BG_COLOR covering every pixel; exactly one clear_done pulse.
//  5. hold high for 5 cycles at pixel 5 of a draw.
//     -> plot=0 for 5 cycles; pixel 5 emitted when hold drops; done delayed by 5 cycles.
//  6. resetn low mid-clear.
//     -> IDLE next edge; plot=0, busy=0, no clear_done; a later draw_req is served normally.

Source files
------------

// File: rtl/draw_scheduler_pkg.sv
// Shared constants, colour codes and state encodings for the frame-buffer write scheduler.
package draw_scheduler_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned XS_W     = X_W + 1;
  localparam int unsigned YS_W     = Y_W + 1;
  localparam int unsigned BLOCK_H  = 4;
  localparam int unsigned COLOR_W  = 3;

  localparam logic [COLOR_W-1:0] COLOR_BLACK   = 3'b000;
  localparam logic [COLOR_W-1:0] COLOR_BLUE    = 3'b001;
  localparam logic [COLOR_W-1:0] COLOR_GREEN   = 3'b010;
  localparam logic [COLOR_W-1:0] COLOR_CYAN    = 3'b011;
  localparam logic [COLOR_W-1:0] COLOR_RED     = 3'b100;
  localparam logic [COLOR_W-1:0] COLOR_MAGENTA = 3'b101;
  localparam logic [COLOR_W-1:0] COLOR_YELLOW  = 3'b110;
  localparam logic [COLOR_W-1:0] COLOR_WHITE   = 3'b111;
  localparam logic [COLOR_W-1:0] BG_COLOR      = COLOR_BLACK;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ERASE = 3'd2,
    ST_DRAW  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic is_scan(state_e s);
    return (s == ST_CLEAR) || (s == ST_ERASE) || (s == ST_DRAW);
  endfunction

endpackage

// File: rtl/draw_scheduler_rect_scan_counter.sv
// Row-major pixel counter for one rectangle scan; freezes while en is low.
module rect_scan_counter
  import draw_scheduler_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  input  logic           clr,
  input  logic           en,
  input  logic [X_W-1:0] w,
  input  logic [Y_W-1:0] h,
  output logic [X_W-1:0] px,
  output logic [Y_W-1:0] py,
  output logic           last
);

  logic row_end;

  assign row_end = (px == w - X_W'(1));
  assign last    = row_end && (py == h - Y_W'(1));

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      px <= '0;
      py <= '0;
    end else if (en) begin
      if (row_end) begin
        px <= '0;
        py <= py + Y_W'(1);
      end else begin
        px <= px + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Arbitrates clear/erase/draw onto the single VGA write port and scans the granted rectangle.
module draw_scheduler
  import draw_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear_req,
  input  logic               erase_req,
  input  logic [X_W-1:0]     erase_x,
  input  logic [Y_W-1:0]     erase_y,
  input  logic [X_W-1:0]     erase_w,
  input  logic               draw_req,
  input  logic [X_W-1:0]     draw_x,
  input  logic [Y_W-1:0]     draw_y,
  input  logic [X_W-1:0]     draw_w,
  input  logic [COLOR_W-1:0] draw_color,
  input  logic               hold,
  output logic               plot,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               clear_done,
  output logic               erase_done,
  output logic               draw_done,
  output logic               busy
);

  state_e             state_q;
  state_e             grant_q;
  logic [X_W-1:0]     base_x_q;
  logic [Y_W-1:0]     base_y_q;
  logic [X_W-1:0]     w_q;
  logic [Y_W-1:0]     h_q;
  logic [COLOR_W-1:0] col_q;

  logic               scan;
  logic [X_W-1:0]     px;
  logic [Y_W-1:0]     py;
  logic               last;
  logic [XS_W-1:0]    sum_x;
  logic [YS_W-1:0]    sum_y;
  logic               in_bounds;

  assign scan = is_scan(state_q);

  rect_scan_counter u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clr    (!scan),
    .en     (scan && !hold),
    .w      (w_q),
    .h      (h_q),
    .px     (px),
    .py     (py),
    .last   (last)
  );

  // Arbiter and scan sequencing; the owner is kept so DONE pulses only its done.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      grant_q  <= ST_IDLE;
      base_x_q <= '0;
      base_y_q <= '0;
      w_q      <= '0;
      h_q      <= '0;
      col_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            base_x_q <= '0;
            base_y_q <= '0;
            w_q      <= X_W'(SCREEN_W);
            h_q      <= Y_W'(SCREEN_H);
            col_q    <= BG_COLOR;
            grant_q  <= ST_CLEAR;
            state_q  <= ST_CLEAR;
          end else if (erase_req) begin
            base_x_q <= erase_x;
            base_y_q <= erase_y;
            w_q      <= erase_w;
            h_q      <= Y_W'(BLOCK_H);
            col_q    <= BG_COLOR;
            grant_q  <= ST_ERASE;
            state_q  <= (erase_w == '0) ? ST_DONE : ST_ERASE;
          end else if (draw_req) begin
            base_x_q <= draw_x;
            base_y_q <= draw_y;
            w_q      <= draw_w;
            h_q      <= Y_W'(BLOCK_H);
            col_q    <= draw_color;
            grant_q  <= ST_DRAW;
            state_q  <= (draw_w == '0) ? ST_DONE : ST_DRAW;
          end
        end
        ST_CLEAR, ST_ERASE, ST_DRAW: begin
          if (!hold && last) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Sums carry one extra bit so wrap-around past the coordinate range clips.
  assign sum_x     = {1'b0, base_x_q} + {1'b0, px};
  assign sum_y     = {1'b0, base_y_q} + {1'b0, py};
  assign in_bounds = (sum_x < XS_W'(SCREEN_W)) && (sum_y < YS_W'(SCREEN_H));

  assign plot       = scan && !hold && in_bounds;
  assign vga_x      = scan ? sum_x[X_W-1:0] : '0;
  assign vga_y      = scan ? sum_y[Y_W-1:0] : '0;
  assign vga_colour = scan ? col_q : '0;
  assign clear_done = (state_q == ST_DONE) && (grant_q == ST_CLEAR);
  assign erase_done = (state_q == ST_DONE) && (grant_q == ST_ERASE);
  assign draw_done  = (state_q == ST_DONE) && (grant_q == ST_DRAW);
  assign busy       = (state_q != ST_IDLE);

endmodule
